// File: rtl/cpu_cmd_issuer.sv
// Command FIFO and issue stage in front of the CPU datapath: one-cycle ce per command, throttled after operations.
// Optional build macro CPU_CMD_ISSUER_STATS_EN adds the 16-bit op_count output.
module cpu_cmd_issuer #(
   parameter int DEPTH  = 8,
   parameter int OP_GAP = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_load,
   input  logic [7:0]             in_opcode,
   input  logic [7:0]             in_data,
   input  logic                   in_cin,
   input  logic                   in_cout,
   output logic                   ce,
   output logic                   load,
   output logic [7:0]             opcode,
   output logic [7:0]             cpu_data,
   output logic                   cin,
   output logic                   cout,
   output logic [$clog2(DEPTH):0] level,
   output logic                   busy
`ifdef CPU_CMD_ISSUER_STATS_EN
   ,
   output logic [15:0]            op_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int GW = $clog2(OP_GAP + 1);

   typedef struct packed {
      logic       load;
      logic [7:0] opcode;
      logic [7:0] data;
      logic       cin;
      logic       cout;
   } entry_t;

   typedef enum logic {S_IDLE, S_HOLD} state_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   entry_t        wr_entry;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   state_t        state;
   state_t        state_next;
   logic [GW-1:0] gap;
   logic [GW-1:0] gap_next;
   logic          push;
   logic          pop;
   logic          empty;
   logic          full;

   assign head     = mem[rd_ptr];
   assign wr_entry = '{load: in_load, opcode: in_opcode, data: in_data, cin: in_cin, cout: in_cout};

   // Flush blocks both the push and the issue of the same cycle.
   always_comb begin
      empty    = (level == '0);
      full     = (level == LW'(DEPTH));
      in_ready = ~full;
      push     = in_valid && !full && !flush;
      pop      = (state == S_IDLE) && !empty && !flush;
      busy     = !empty || ce || (state == S_HOLD);
   end

   // NOTE: storage has no reset; level gates every read, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         gap   <= '0;
      end else begin
         state <= state_next;
         gap   <= gap_next;
      end
   end

   // HOLD is left when the counter reads 1, giving OP_GAP idle cycles after an operation.
   always_comb begin
      state_next = state;
      gap_next   = gap;
      case (state)
         S_IDLE: begin
            if (pop && !head.load) begin
               state_next = S_HOLD;
               gap_next   = GW'(OP_GAP);
            end
         end
         S_HOLD: begin
            if (gap == GW'(1)) state_next = S_IDLE;
            else               gap_next   = gap - 1'b1;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ce       <= 1'b0;
         load     <= 1'b0;
         opcode   <= '0;
         cpu_data <= '0;
         cin      <= 1'b0;
         cout     <= 1'b0;
      end else begin
         ce <= pop;
         if (pop) begin
            load     <= head.load;
            opcode   <= head.opcode;
            cpu_data <= head.data;
            cin      <= head.cin;
            cout     <= head.cout;
         end
      end
   end

`ifdef CPU_CMD_ISSUER_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     op_count <= '0;
      else if (pop && !head.load)  op_count <= op_count + 16'd1;
   end
`endif

endmodule
